// File: rtl/fp_mulsub_arbiter_if.sv
// Requester/unit-facing bundle of the mul-sub arbiter: issue handshake, unit
// operand/result bus and the response return path.
interface fp_mulsub_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic                 en;
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [32*NREQ-1:0]   req_c;
  logic [NREQ-1:0]      gnt;
  logic [31:0]          u_a;
  logic [31:0]          u_b;
  logic [31:0]          u_c;
  logic                 u_en;
  logic [31:0]          u_result;
  logic [NREQ-1:0]      rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;
  logic                 busy;

  modport master (
    output en, req, req_a, req_b, req_c, u_result,
    input  gnt, u_a, u_b, u_c, u_en, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  en, req, req_a, req_b, req_c, u_result,
    output gnt, u_a, u_b, u_c, u_en, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/fp_mulsub_arbiter.sv
// Round-robin scheduler sharing one pipelined A*B-C unit among NREQ requesters;
// a {valid,id} shift pipeline routes each result back to the requester that issued it.
module fp_mulsub_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  fp_mulsub_arbiter_if.slave bus
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt_c;
  logic            issue;
  logic [IDW:0]    idx;
  logic            remain;
  logic [LAT-1:0]  tag_valid;
  logic [IDW-1:0]  tag_id [LAT];

  // First requester at or above the pointer wins, wrapping past NREQ-1.
  always_comb begin
    gnt_c   = '0;
    gnt_idx = '0;
    issue   = 1'b0;
    idx     = '0;
    if (!rst && bus.en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = {1'b0, ptr} + (IDW+1)'(k);
        if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
        if (!issue && bus.req[idx[IDW-1:0]]) begin
          issue                 = 1'b1;
          gnt_idx               = idx[IDW-1:0];
          gnt_c[idx[IDW-1:0]]   = 1'b1;
        end
      end
    end
  end

  // Unit stays enabled while anything is still in the tag pipeline after the shift.
  always_comb begin
    remain = issue;
    for (int s = 0; s < LAT - 1; s++) remain = remain | tag_valid[s];
  end

  assign bus.gnt  = gnt_c;
  assign bus.busy = |tag_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      tag_valid     <= '0;
      for (int s = 0; s < LAT; s++) tag_id[s] <= '0;
      bus.u_a       <= '0;
      bus.u_b       <= '0;
      bus.u_c       <= '0;
      bus.u_en      <= 1'b0;
      bus.rsp_valid <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      if (issue) begin
        ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        bus.u_a <= bus.req_a[{gnt_idx, 5'd0} +: 32];
        bus.u_b <= bus.req_b[{gnt_idx, 5'd0} +: 32];
        bus.u_c <= bus.req_c[{gnt_idx, 5'd0} +: 32];
      end
      tag_valid[0] <= issue;
      tag_id[0]    <= gnt_idx;
      for (int s = 1; s < LAT; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
      bus.u_en <= remain;
      if (tag_valid[LAT-1]) begin
        bus.rsp_valid <= NREQ'(1) << tag_id[LAT-1];
        bus.rsp_id    <= tag_id[LAT-1];
        bus.rsp_data  <= bus.u_result;
      end else begin
        bus.rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mulsub_arbiter.sv
// Bench for fp_mulsub_arbiter: directed scenarios followed by a random phase, all
// checked every cycle against a queue-based round-robin/response model.
module tb_fp_mulsub_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 2;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ptr_m = 0;
  int   last_id = 0;
  int   pulses1 = 0;
  logic [31:0] last_data = '0;
  logic [31:0] last_ua = '0;
  logic [31:0] last_uc = '0;
  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];
  logic [31:0] op_c [NREQ];
  logic [NREQ-1:0] g;
  op_t pend [$];

  fp_mulsub_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fp_mulsub_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic real sgl2real(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] dbl2sgl(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fmsub(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    return dbl2sgl(sgl2real(a) * sgl2real(b) - sgl2real(c));
  endfunction

  // Small integers keep A*B-C exact in single precision.
  function automatic logic [31:0] rndf();
    int v;
    v = int'($urandom_range(32)) - 16;
    return dbl2sgl(real'(v));
  endfunction

  // Fully pipelined unit: result valid LAT cycles after the grant cycle.
  always @(posedge clk) bus.u_result <= fmsub(bus.u_a, bus.u_b, bus.u_c);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic compareModel();
    logic [NREQ-1:0] ev;
    ev = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev        = NREQ'(1) << pend[0].id;
      last_data = pend[0].data;
      last_id   = pend[0].id;
      pend.delete(0);
    end
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    checkOutput("rsp_data", bus.rsp_data, last_data);
    checkOutput("rsp_id", 32'(bus.rsp_id), 32'(last_id));
    checkOutput("busy", 32'(bus.busy), 32'(pend.size() > 0));
    checkOutput("u_en", 32'(bus.u_en), 32'(pend.size() > 0));
    checkOutput("u_a", bus.u_a, last_ua);
    checkOutput("u_c", bus.u_c, last_uc);
    if (bus.rsp_valid === 4'b0010) pulses1++;
  endtask

  task automatic applyStimulus(input logic e, input logic [NREQ-1:0] r, input logic rs,
                               input bit rnd, output logic [NREQ-1:0] got);
    logic [NREQ-1:0] eg;
    int gi;
    op_t op;
    @(negedge clk);
    cyc++;
    compareModel();
    if (rnd) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = rndf();
        op_b[i] = rndf();
        op_c[i] = rndf();
      end
    end
    rst     = rs;
    bus.en  = e;
    bus.req = r;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[32*i +: 32] = op_a[i];
      bus.req_b[32*i +: 32] = op_b[i];
      bus.req_c[32*i +: 32] = op_c[i];
    end
    #1;
    eg = '0;
    gi = -1;
    if (!rs && e) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (ptr_m + k) % NREQ;
        if (gi < 0 && r[j]) gi = j;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    checkOutput("gnt", 32'(bus.gnt), 32'(eg));
    got = bus.gnt;
    if (rs) begin
      pend.delete();
      ptr_m     = 0;
      last_data = '0;
      last_id   = 0;
      last_ua   = '0;
      last_uc   = '0;
    end else if (gi >= 0) begin
      op.id   = gi;
      op.data = fmsub(op_a[gi], op_b[gi], op_c[gi]);
      op.due  = cyc + LAT + 1;
      pend.push_back(op);
      last_ua = op_a[gi];
      last_uc = op_c[gi];
      ptr_m   = (gi + 1) % NREQ;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      op_c[i] = '0;
    end
    repeat (2) @(posedge clk);

    // Single request: 3*2-1 = 5.0 returns three cycles after the grant.
    op_a[0] = 32'h40400000;
    op_b[0] = 32'h40000000;
    op_c[0] = 32'h3F800000;
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, g);
    checkOutput("t1_gnt", 32'(g), 32'h1);
    repeat (3) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, g);
    checkOutput("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("t1_rsp_data", bus.rsp_data, 32'h40A00000);
    checkOutput("t1_rsp_id", 32'(bus.rsp_id), 32'h0);

    // All four requesting continuously from a fresh pointer.
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, g);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, g);
      checkOutput("t2_gnt", 32'(g), 32'(1 << (k % 4)));
    end
    repeat (4) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, g);

    // Fairness: after requester 0 wins, 3 outranks 0.
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, g);
    checkOutput("t3_gnt0", 32'(g), 32'b0001);
    applyStimulus(1'b1, 4'b1001, 1'b0, 1'b1, g);
    checkOutput("t3_gnt3", 32'(g), 32'b1000);
    applyStimulus(1'b1, 4'b1001, 1'b0, 1'b1, g);
    checkOutput("t3_gnt0b", 32'(g), 32'b0001);
    repeat (4) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, g);

    // en low with two ops in flight.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, g);
    checkOutput("t4_gnt1", 32'(g), 32'b0010);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, g);
    checkOutput("t4_gnt2", 32'(g), 32'b0100);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, g);
      checkOutput("t4_gnt_off", 32'(g), 32'h0);
    end
    checkOutput("t4_rsp_last", 32'(bus.rsp_valid), 32'b0100);
    checkOutput("t4_busy", 32'(bus.busy), 32'h0);
    checkOutput("t4_u_en", 32'(bus.u_en), 32'h0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, g);
    checkOutput("t4_resume", 32'(g), 32'b1000);
    repeat (4) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, g);

    // Reset one cycle after an issue discards it and restarts the pointer.
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, g);
    checkOutput("t5_gnt", 32'(g), 32'b0100);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1, g);
    checkOutput("t5_gnt_rst", 32'(g), 32'h0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, g);
    checkOutput("t5_gnt_ptr0", 32'(g), 32'b0001);
    checkOutput("t5_u_a", bus.u_a, 32'h0);
    checkOutput("t5_rsp_data", bus.rsp_data, 32'h0);
    checkOutput("t5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    repeat (5) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, g);

    // Back-to-back issues to one requester.
    pulses1 = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1, g);
      checkOutput("t6_gnt", 32'(g), 32'b0010);
    end
    repeat (3) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, g);
    checkOutput("t6_pulses", 32'(pulses1), 32'd4);

    // Random traffic with occasional en drops and resets.
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom_range(7) != 0), NREQ'($urandom), 1'($urandom_range(49) == 0),
                    1'b1, g);
    end
    repeat (5) applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, g);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
